// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared constants for the boot-time program loader: FSM state
//               encoding, length-field size and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package program_loader_pkg;

  // Number of bytes in the big-endian length field that opens every frame
  localparam int c_len_bytes = 4;

  typedef logic [2:0] state_t;

  localparam state_t c_st_idle = 3'd0;
  localparam state_t c_st_len  = 3'd1;
  localparam state_t c_st_load = 3'd2;
  localparam state_t c_st_csum = 3'd3;
  localparam state_t c_st_run  = 3'd4;
  localparam state_t c_st_err  = 3'd5;

  // Payload index needs one extra bit so that MAX_BYTES itself is representable
  function automatic int idx_width(input int max_bytes);
    return $clog2(max_bytes) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_if.sv
// ============================================================================
// Module      : program_loader_if
// Description : Byte-stream input (valid/ready) and instruction-memory write
//               bus of the program loader. The loader uses the slave view:
//               it sinks the stream and drives the write bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface program_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] write_address;
  logic [7:0]  write_data;
  logic        We;

  // Environment side: feeds the stream, observes the memory writes
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  write_address,
    input  write_data,
    input  We
  );

  // Loader side: consumes the stream, drives the memory writes
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output write_address,
    output write_data,
    output We
  );

endinterface

`default_nettype wire

// File: rtl/program_loader_csum.sv
// ============================================================================
// Module      : program_loader_csum
// Description : Running XOR of payload bytes with clear, accumulate and a
//               combinational compare against the incoming checksum byte.
//               Only built when PROGRAM_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef PROGRAM_LOADER_CHECKSUM_EN
module program_loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       accum,
  input  logic [7:0] data,
  output logic       match
);

  logic [7:0] r_acc;

  // XOR accumulator; clear wins so a new frame always starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 8'h00;
    end else if (clear) begin
      r_acc <= 8'h00;
    end else if (accum) begin
      r_acc <= r_acc ^ data;
    end
  end

  assign match = (r_acc == data);

endmodule
`endif

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader. Receives a framed byte stream (4-byte
//               big-endian length, payload, optional XOR checksum byte) and
//               writes the payload byte-by-byte into instruction memory,
//               holding the processor stalled until a legal image is loaded.
//               Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds the
//               CSUM state and the trailing checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MAX_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  program_loader_if.slave bus,
  output logic            pc_enable,
  output logic            busy,
  output logic            load_error
);

  localparam int c_idx_w = idx_width(MAX_BYTES);

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_len;
  logic [1:0]           r_len_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_we;
  logic [31:0]          r_waddr;
  logic [7:0]           r_wdata;
  logic                 r_pc_en;

  logic                 w_in_frame;
  logic                 w_acc;
  logic                 w_start_ok;
  logic [31:0]          w_len_full;
  logic                 w_len_ok;
  logic                 w_len_done;
  logic                 w_last;

  // Stream is open only while a frame is being received
  assign w_in_frame = (r_state == c_st_len) || (r_state == c_st_load) ||
                      (r_state == c_st_csum);
  assign w_acc      = bus.rx_valid && w_in_frame;
  // start is ignored while busy
  assign w_start_ok = start && ((r_state == c_st_idle) || (r_state == c_st_run) ||
                                (r_state == c_st_err));

  // Length as it will look once the current byte is shifted in
  assign w_len_full = {r_len[23:0], bus.rx_data};
  assign w_len_ok   = (w_len_full != 32'd0) && (w_len_full <= 32'(MAX_BYTES)) &&
                      (w_len_full[1:0] == 2'b00);
  assign w_len_done = (r_len_cnt == 2'(c_len_bytes - 1));
  assign w_last     = (32'(r_idx) == (r_len - 32'd1));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic w_csum_match;

  program_loader_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_start_ok),
    .accum (w_acc && (r_state == c_st_load)),
    .data  (bus.rx_data),
    .match (w_csum_match)
  );
`endif

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle, c_st_run, c_st_err: begin
        if (start) w_next = c_st_len;
      end
      c_st_len: begin
        if (w_acc && w_len_done) w_next = w_len_ok ? c_st_load : c_st_err;
      end
      c_st_load: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (w_acc && w_last) w_next = c_st_csum;
`else
        if (w_acc && w_last) w_next = c_st_run;
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      c_st_csum: begin
        if (w_acc) w_next = w_csum_match ? c_st_run : c_st_err;
      end
`endif
      default: w_next = c_st_idle;
    endcase
  end

  // State, length shifter, payload index and registered write outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_len     <= 32'd0;
      r_len_cnt <= 2'd0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_waddr   <= 32'd0;
      r_wdata   <= 8'h00;
      r_pc_en   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      // Delayed by one cycle on entry so the processor starts after the final write
      r_pc_en <= (r_state == c_st_run) && (w_next == c_st_run);
      if (w_start_ok) begin
        r_len     <= 32'd0;
        r_len_cnt <= 2'd0;
      end
      if (w_acc && (r_state == c_st_len)) begin
        r_len     <= w_len_full;
        r_len_cnt <= r_len_cnt + 2'd1;
        r_idx     <= '0;
      end
      if (w_acc && (r_state == c_st_load)) begin
        r_we    <= 1'b1;
        r_waddr <= BASE_ADDR + 32'(r_idx);
        r_wdata <= bus.rx_data;
        r_idx   <= r_idx + {{(c_idx_w-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.rx_ready      = w_in_frame;
  assign bus.We            = r_we;
  assign bus.write_address = r_waddr;
  assign bus.write_data    = r_wdata;
  assign pc_enable         = r_pc_en;
  assign busy              = w_in_frame;
  assign load_error        = (r_state == c_st_err);

endmodule

`default_nettype wire
